dense_argmax_engine: RTL and testbench

- Classifier back end that sits directly downstream of the 2-channel 3x3 convolution stage.
- Buffers one flattened feature frame of N_IN activations. Computes N_OUT dense-layer scores with one multiply-accumulate per cycle, using 6-bit signed weights and biases read from an external ROM. Emits the winning class index and its score.

---
 rtl/dense_argmax_engine_if.sv | 36 +++
 rtl/dense_argmax_engine.sv | 147 ++++++++++++++
 tb/tb_dense_argmax_engine.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/dense_argmax_engine_if.sv
// Bundles the activation stream, weight/bias ROM ports and result handshake of dense_argmax_engine.
// The engine takes the slave modport; the driving environment takes the master modport.
interface dense_argmax_engine_if #(
  parameter int N_IN  = 128,
  parameter int N_OUT = 10,
  parameter int ACT_W = 8,
  parameter int W_W   = 6,
  parameter int ACC_W = 24
);
  localparam int WA_W  = $clog2(N_IN * N_OUT);
  localparam int CLS_W = $clog2(N_OUT);

  logic [ACT_W-1:0]        in_data;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;
  logic [WA_W-1:0]         w_addr;
  logic signed [W_W-1:0]   w_data;
  logic [CLS_W-1:0]        b_addr;
  logic signed [W_W-1:0]   b_data;
  logic [CLS_W-1:0]        out_class;
  logic signed [ACC_W-1:0] out_score;
  logic                    out_valid;
  logic                    out_ready;
  logic                    frame_err;

  modport slave (
    input  in_data, in_valid, in_last, w_data, b_data, out_ready,
    output in_ready, w_addr, b_addr, out_class, out_score, out_valid, frame_err
  );

  modport master (
    output in_data, in_valid, in_last, w_data, b_data, out_ready,
    input  in_ready, w_addr, b_addr, out_class, out_score, out_valid, frame_err
  );
endinterface

// File: rtl/dense_argmax_engine.sv
// Buffers one activation frame, evaluates a dense layer one MAC per cycle against external
// weight/bias ROMs, and reports the highest-scoring class (ties resolve to the lowest index).
module dense_argmax_engine #(
  parameter int N_IN  = 128,
  parameter int N_OUT = 10,
  parameter int ACT_W = 8,
  parameter int W_W   = 6,
  parameter int ACC_W = 24
) (
  input logic clk,
  input logic rst_n,
  dense_argmax_engine_if.slave bus
);
  localparam int IDX_W  = $clog2(N_IN);
  localparam int STEP_W = $clog2(N_IN + 2);
  localparam int CLS_W  = $clog2(N_OUT);
  localparam int WA_W   = $clog2(N_IN * N_OUT);
  localparam int PROD_W = ACT_W + W_W + 1;

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        cnt_reg;
  logic [STEP_W-1:0]       step_reg;
  logic [CLS_W-1:0]        o_reg;
  logic [WA_W-1:0]         w_addr_reg;
  logic [CLS_W-1:0]        b_addr_reg;
  logic signed [ACC_W-1:0] acc_reg, best_reg, out_score_reg;
  logic [CLS_W-1:0]        best_class_reg, out_class_reg;
  logic                    out_valid_reg, frame_err_reg;

  logic [ACT_W-1:0]        buffer [N_IN];
  logic [ACT_W-1:0]        act_reg;

  logic                    accept, cnt_last, step_last, o_last;
  logic [IDX_W-1:0]        rd_idx;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0] prod_ext, bias_ext, acc_base;

  assign accept    = bus.in_valid && (state_reg == LOAD);
  assign cnt_last  = (cnt_reg == IDX_W'(N_IN - 1));
  assign step_last = (step_reg == STEP_W'(N_IN + 1));
  assign o_last    = (o_reg == CLS_W'(N_OUT - 1));

  // Buffer read is one step ahead so act_reg lines up with w_data on steps 1..N_IN.
  assign rd_idx   = (step_reg < STEP_W'(N_IN)) ? step_reg[IDX_W-1:0] : '0;
  assign prod     = PROD_W'($signed({1'b0, act_reg})) * PROD_W'(bus.w_data);
  assign prod_ext = ACC_W'(prod);
  assign bias_ext = ACC_W'(bus.b_data);
  assign acc_base = (step_reg == STEP_W'(1)) ? bias_ext : acc_reg;

  always_ff @(posedge clk) begin
    if (accept) buffer[cnt_reg] <= bus.in_data;
    act_reg <= buffer[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= LOAD;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD:    if (accept && cnt_last) state_next = COMPUTE;
      COMPUTE: if (step_last && o_last) state_next = OUTPUT;
      OUTPUT:  if (out_valid_reg && bus.out_ready) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      step_reg       <= '0;
      o_reg          <= '0;
      w_addr_reg     <= '0;
      b_addr_reg     <= '0;
      acc_reg        <= '0;
      best_reg       <= '0;
      best_class_reg <= '0;
      out_score_reg  <= '0;
      out_class_reg  <= '0;
      out_valid_reg  <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;
      case (state_reg)
        LOAD: begin
          if (accept) begin
            if (bus.in_last && !cnt_last) begin
              cnt_reg       <= '0;
              frame_err_reg <= 1'b1;
            end else if (cnt_last) begin
              cnt_reg       <= '0;
              frame_err_reg <= !bus.in_last;
              step_reg      <= '0;
              o_reg         <= '0;
              w_addr_reg    <= '0;
              b_addr_reg    <= '0;
            end else begin
              cnt_reg <= cnt_reg + IDX_W'(1);
            end
          end
        end
        COMPUTE: begin
          if (step_last) begin
            step_reg <= '0;
            if (o_reg == '0 || acc_reg > best_reg) begin
              best_reg       <= acc_reg;
              best_class_reg <= o_reg;
            end
            // w_addr already sits on the last weight of o, so +1 lands on (o+1)*N_IN.
            if (!o_last) begin
              o_reg      <= o_reg + CLS_W'(1);
              b_addr_reg <= b_addr_reg + CLS_W'(1);
              w_addr_reg <= w_addr_reg + WA_W'(1);
            end
          end else begin
            step_reg <= step_reg + STEP_W'(1);
            if (step_reg != '0) acc_reg <= acc_base + prod_ext;
            if (step_reg < STEP_W'(N_IN - 1)) w_addr_reg <= w_addr_reg + WA_W'(1);
          end
        end
        OUTPUT: begin
          if (!out_valid_reg) begin
            out_class_reg <= best_class_reg;
            out_score_reg <= best_reg;
            out_valid_reg <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            cnt_reg       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == LOAD);
  assign bus.w_addr    = w_addr_reg;
  assign bus.b_addr    = b_addr_reg;
  assign bus.out_class = out_class_reg;
  assign bus.out_score = out_score_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.frame_err = frame_err_reg;
endmodule

// File: tb/tb_dense_argmax_engine.sv
// Randomized bench for dense_argmax_engine: synchronous ROM models, a plain-arithmetic
// dense-layer/argmax reference, and directed framing, backpressure and reset scenarios.
module tb_dense_argmax_engine;
  localparam int N_IN  = 128;
  localparam int N_OUT = 10;
  localparam int ACT_W = 8;
  localparam int W_W   = 6;
  localparam int ACC_W = 24;
  localparam int LATENCY = N_OUT * (N_IN + 2) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  dense_argmax_engine_if #(.N_IN(N_IN), .N_OUT(N_OUT), .ACT_W(ACT_W), .W_W(W_W), .ACC_W(ACC_W)) bus ();

  dense_argmax_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .ACT_W(ACT_W), .W_W(W_W), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [ACT_W-1:0]      act_mem [N_IN];
  logic signed [W_W-1:0] w_rom [N_IN*N_OUT];
  logic signed [W_W-1:0] b_rom [N_OUT];

  // ROMs with one-cycle read latency
  always @(posedge clk) begin
    bus.w_data <= w_rom[bus.w_addr];
    bus.b_data <= b_rom[bus.b_addr];
  end

  task automatic check_eq(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ref_model(output int cls, output longint best);
    longint s;
    cls = 0;
    best = 0;
    for (int o = 0; o < N_OUT; o++) begin
      s = longint'(b_rom[o]);
      for (int i = 0; i < N_IN; i++)
        s += longint'(act_mem[i]) * longint'(w_rom[o*N_IN + i]);
      if (o == 0 || s > best) begin
        best = s;
        cls = o;
      end
    end
  endtask

  task automatic randomize_all();
    for (int i = 0; i < N_IN; i++) act_mem[i] = ACT_W'($urandom);
    for (int k = 0; k < N_IN*N_OUT; k++) w_rom[k] = W_W'($urandom);
    for (int o = 0; o < N_OUT; o++) b_rom[o] = W_W'($urandom);
  endtask

  task automatic fill(input int act, input int w, input int b);
    for (int i = 0; i < N_IN; i++) act_mem[i] = ACT_W'(act);
    for (int k = 0; k < N_IN*N_OUT; k++) w_rom[k] = W_W'(w);
    for (int o = 0; o < N_OUT; o++) b_rom[o] = W_W'(b);
  endtask

  task automatic set_class_weights(input int o, input int w);
    for (int i = 0; i < N_IN; i++) w_rom[o*N_IN + i] = W_W'(w);
  endtask

  // Drives n beats from act_mem, with random idle gaps; returns #1 after the last accepting edge.
  task automatic drive_frame(input int n, input bit mark_last);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3) == 0) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b1;
        bus.in_data  = ACT_W'($urandom);
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = act_mem[i];
      bus.in_last  = mark_last && (i == n - 1);
      @(posedge clk);
    end
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic run_frame(input string name, input bit mark_last, input int hold);
    int cls;
    longint sc;
    int cyc;
    bit ready_seen;
    logic [31:0] w_addr_held;
    ref_model(cls, sc);
    drive_frame(N_IN, mark_last);
    check_eq({name, ".frame_err"}, bus.frame_err, !mark_last);
    cyc = 0;
    ready_seen = 1'b0;
    while (!bus.out_valid && cyc < 2 * LATENCY) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.in_ready) ready_seen = 1'b1;
    end
    check_eq({name, ".out_valid"}, bus.out_valid, 1);
    check_eq({name, ".latency"}, cyc, LATENCY);
    check_eq({name, ".in_ready_busy"}, ready_seen, 0);
    check_eq({name, ".class"}, bus.out_class, cls);
    check_eq({name, ".score"}, $signed(bus.out_score), sc);
    $display("frame %s: class %0d score %0d latency %0d (model class %0d score %0d)",
             name, bus.out_class, $signed(bus.out_score), cyc, cls, sc);
    w_addr_held = 32'(bus.w_addr);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check_eq({name, ".hold_valid"}, bus.out_valid, 1);
      check_eq({name, ".hold_ready"}, bus.in_ready, 0);
      check_eq({name, ".hold_class"}, bus.out_class, cls);
      check_eq({name, ".hold_score"}, $signed(bus.out_score), sc);
      check_eq({name, ".hold_w_addr"}, bus.w_addr, w_addr_held);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_eq({name, ".post_valid"}, bus.out_valid, 0);
    check_eq({name, ".post_ready"}, bus.in_ready, 1);
    check_eq({name, ".post_class"}, bus.out_class, cls);
  endtask

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    fill(0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.in_ready", bus.in_ready, 1);
    check_eq("rst.out_valid", bus.out_valid, 0);
    check_eq("rst.out_class", bus.out_class, 0);
    check_eq("rst.out_score", $signed(bus.out_score), 0);
    check_eq("rst.frame_err", bus.frame_err, 0);
    check_eq("rst.w_addr", bus.w_addr, 0);
    check_eq("rst.b_addr", bus.b_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // All-zero activations: biases alone decide, class 9 with score 1.
    randomize_all();
    for (int i = 0; i < N_IN; i++) act_mem[i] = '0;
    for (int o = 0; o < N_OUT; o++) b_rom[o] = W_W'(-1);
    b_rom[1] = W_W'(-2);
    b_rom[2] = W_W'(0);
    b_rom[9] = W_W'(1);
    run_frame("zero_act", 1'b1, 0);
    check_eq("zero_act.spec_class", bus.out_class, 9);
    check_eq("zero_act.spec_score", $signed(bus.out_score), 1);

    fill(255, 0, 0);
    set_class_weights(3, 1);
    run_frame("class3", 1'b1, 0);
    check_eq("class3.spec_score", $signed(bus.out_score), 32640);

    fill(10, -1, 0);
    set_class_weights(2, 1);
    set_class_weights(5, 1);
    run_frame("tie", 1'b1, 0);
    check_eq("tie.spec_class", bus.out_class, 2);

    fill(255, -32, -32);
    run_frame("most_negative", 1'b1, 0);
    check_eq("most_negative.spec_score", $signed(bus.out_score), -1044512);

    // Early in_last discards the partial frame; the next full frame must be unaffected.
    randomize_all();
    drive_frame(50, 1'b1);
    check_eq("early.frame_err", bus.frame_err, 1);
    begin
      bit valid_seen = 1'b0;
      bit ready_low = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk);
        #1;
        if (bus.out_valid) valid_seen = 1'b1;
        if (!bus.in_ready) ready_low = 1'b1;
      end
      check_eq("early.no_valid", valid_seen, 0);
      check_eq("early.ready_low", ready_low, 0);
      check_eq("early.err_pulse_ends", bus.frame_err, 0);
    end
    run_frame("after_early", 1'b1, 0);

    randomize_all();
    run_frame("missing_last", 1'b0, 0);

    randomize_all();
    run_frame("backpressure", 1'b1, 20);

    // Reset mid-COMPUTE: engine returns to LOAD at once and the next frame is clean.
    randomize_all();
    drive_frame(N_IN, 1'b1);
    repeat (300) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst.in_ready", bus.in_ready, 1);
    check_eq("midrst.out_valid", bus.out_valid, 0);
    check_eq("midrst.w_addr", bus.w_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    randomize_all();
    run_frame("after_reset", 1'b1, 0);

    for (int r = 0; r < 3; r++) begin
      randomize_all();
      run_frame($sformatf("random%0d", r), 1'b1, $urandom_range(3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
